// File: rtl/cordic_share_ctrl_pkg.sv
// Shared types and constants for the CORDIC sharing controller.
//   state_e      : controller FSM state encoding
//   DATA_W_DEF   : default operand/result width (signed Q0.7)
//   TIMEOUT_DEF  : default WAIT cycle budget before abort
//   CORE_LATENCY : nominal latency of the external iterative core
package cordic_ctrl_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned TIMEOUT_DEF  = 32;
  localparam int unsigned CORE_LATENCY = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/cordic_share_ctrl_if.sv
// One requester channel of the CORDIC sharing controller: request
// (operands in) and response (results out) handshakes.
//   master : the requester side (drives req, consumes rsp)
//   slave  : the controller side (consumes req, drives rsp)
interface cordic_share_ctrl_if #(
  parameter int unsigned DATA_W = 8
);

  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_x;
  logic [DATA_W-1:0] req_z;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_x;
  logic [DATA_W-1:0] rsp_y;
  logic              rsp_err;

  modport master (
    output req_valid, req_x, req_z, rsp_ready,
    input  req_ready, rsp_valid, rsp_x, rsp_y, rsp_err
  );

  modport slave (
    input  req_valid, req_x, req_z, rsp_ready,
    output req_ready, rsp_valid, rsp_x, rsp_y, rsp_err
  );

endinterface

// File: rtl/cordic_rr_arb.sv
// Two-way round-robin arbiter.
//   req  : request vector (bit n = channel n valid)
//   last : channel served most recently
//   gnt  : one-hot grant, zero when nothing requests
module cordic_rr_arb (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // On a tie the channel that was not served last wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/cordic_share_ctrl.sv
// Shares one external iterative CORDIC core between two requesters,
// one transaction in flight at a time, with a WAIT timeout.
//   clk_i, rstn_i                 : clock, async active-low reset
//   reqN_valid/ready/X/Z          : per-channel request handshake
//   rspN_valid/ready/X/Y/err      : per-channel response handshake
//   core_strb_o, core_X_o/Z_o     : core launch
//   core_valid_i, core_X_i/Y_i    : core result
//   busy_o, timeout_o             : not-idle, sticky abort flag
module cordic_share_ctrl
  import cordic_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_X_i,
  input  logic [DATA_W-1:0] req0_Z_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_X_i,
  input  logic [DATA_W-1:0] req1_Z_i,
  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic [DATA_W-1:0] rsp0_X_o,
  output logic [DATA_W-1:0] rsp0_Y_o,
  output logic              rsp0_err_o,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [DATA_W-1:0] rsp1_X_o,
  output logic [DATA_W-1:0] rsp1_Y_o,
  output logic              rsp1_err_o,
  output logic              core_strb_o,
  output logic [DATA_W-1:0] core_X_o,
  output logic [DATA_W-1:0] core_Z_o,
  input  logic [DATA_W-1:0] core_X_i,
  input  logic [DATA_W-1:0] core_Y_i,
  input  logic              core_valid_i,
  output logic              busy_o,
  output logic              timeout_o
);

  localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_e            state;
  logic              owner;
  logic              last;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] op_x, op_z, res_x, res_y;
  logic              err;
  logic              tmo;
  logic [1:0]        rsp_vld;
  logic [1:0]        rst_sync;
  logic              rst_n;
  logic [1:0]        gnt, rdy, rsp_rdy;
  logic              accept, acc_ch;

  // Assert asynchronously, release two edges after rstn_i rises.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  cordic_rr_arb u_arb (
    .req  ({req1_valid_i, req0_valid_i}),
    .last (last),
    .gnt  (gnt)
  );

  // Ready only in IDLE and only for the granted (hence valid) channel.
  assign rdy     = (rst_n && state == ST_IDLE) ? gnt : 2'b00;
  assign accept  = |rdy;
  assign acc_ch  = rdy[1];
  assign rsp_rdy = {rsp1_ready_i, rsp0_ready_i};

  // Transaction FSM with its datapath registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      cnt     <= '0;
      op_x    <= '0;
      op_z    <= '0;
      res_x   <= '0;
      res_y   <= '0;
      err     <= 1'b0;
      tmo     <= 1'b0;
      rsp_vld <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            owner <= acc_ch;
            op_x  <= acc_ch ? req1_X_i : req0_X_i;
            op_z  <= acc_ch ? req1_Z_i : req0_Z_i;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_valid_i) begin
            res_x   <= core_X_i;
            res_y   <= core_Y_i;
            err     <= 1'b0;
            rsp_vld <= owner ? 2'b10 : 2'b01;
            state   <= ST_RESP;
          end else if (cnt >= CNT_MAX - CNT_W'(1)) begin
            // Budget exhausted: abort with zero results; counter pins at max.
            cnt     <= CNT_MAX;
            res_x   <= '0;
            res_y   <= '0;
            err     <= 1'b1;
            tmo     <= 1'b1;
            rsp_vld <= owner ? 2'b10 : 2'b01;
            state   <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if ((rsp_vld & rsp_rdy) != 2'b00) begin
            last    <= owner;
            rsp_vld <= 2'b00;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req0_ready_o = rdy[0];
  assign req1_ready_o = rdy[1];
  assign rsp0_valid_o = rsp_vld[0];
  assign rsp1_valid_o = rsp_vld[1];
  assign rsp0_err_o   = rsp_vld[0] & err;
  assign rsp1_err_o   = rsp_vld[1] & err;
  assign rsp0_X_o     = res_x;
  assign rsp0_Y_o     = res_y;
  assign rsp1_X_o     = res_x;
  assign rsp1_Y_o     = res_y;
  assign core_strb_o  = (state == ST_ISSUE);
  assign core_X_o     = op_x;
  assign core_Z_o     = op_z;
  assign busy_o       = (state != ST_IDLE);
  assign timeout_o    = tmo;

endmodule

// File: tb/tb_cordic_share_ctrl.sv
// Self-checking bench for cordic_share_ctrl with a behavioural core model.
module tb_cordic_share_ctrl;
  import cordic_ctrl_pkg::*;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [1:0]    req_valid, rsp_ready, req_ready, rsp_valid, rsp_err;
  logic [DW-1:0] req_x [2];
  logic [DW-1:0] req_z [2];
  logic [DW-1:0] rsp_x [2];
  logic [DW-1:0] rsp_y [2];
  logic          core_strb, core_valid, busy, tmo;
  logic [DW-1:0] core_xo, core_zo, core_xi, core_yi;

  cordic_share_ctrl_if #(.DATA_W(DW)) ch0 ();
  cordic_share_ctrl_if #(.DATA_W(DW)) ch1 ();

  assign ch0.req_valid = req_valid[0];
  assign ch0.req_x     = req_x[0];
  assign ch0.req_z     = req_z[0];
  assign ch0.rsp_ready = rsp_ready[0];
  assign ch1.req_valid = req_valid[1];
  assign ch1.req_x     = req_x[1];
  assign ch1.req_z     = req_z[1];
  assign ch1.rsp_ready = rsp_ready[1];
  assign req_ready = {ch1.req_ready, ch0.req_ready};
  assign rsp_valid = {ch1.rsp_valid, ch0.rsp_valid};
  assign rsp_err   = {ch1.rsp_err, ch0.rsp_err};
  assign rsp_x[0]  = ch0.rsp_x;
  assign rsp_y[0]  = ch0.rsp_y;
  assign rsp_x[1]  = ch1.rsp_x;
  assign rsp_y[1]  = ch1.rsp_y;

  cordic_share_ctrl #(.DATA_W(DW), .TIMEOUT_CYCLES(32)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .req0_valid_i (ch0.req_valid),
    .req0_ready_o (ch0.req_ready),
    .req0_X_i     (ch0.req_x),
    .req0_Z_i     (ch0.req_z),
    .req1_valid_i (ch1.req_valid),
    .req1_ready_o (ch1.req_ready),
    .req1_X_i     (ch1.req_x),
    .req1_Z_i     (ch1.req_z),
    .rsp0_valid_o (ch0.rsp_valid),
    .rsp0_ready_i (ch0.rsp_ready),
    .rsp0_X_o     (ch0.rsp_x),
    .rsp0_Y_o     (ch0.rsp_y),
    .rsp0_err_o   (ch0.rsp_err),
    .rsp1_valid_o (ch1.rsp_valid),
    .rsp1_ready_i (ch1.rsp_ready),
    .rsp1_X_o     (ch1.rsp_x),
    .rsp1_Y_o     (ch1.rsp_y),
    .rsp1_err_o   (ch1.rsp_err),
    .core_strb_o  (core_strb),
    .core_X_o     (core_xo),
    .core_Z_o     (core_zo),
    .core_X_i     (core_xi),
    .core_Y_i     (core_yi),
    .core_valid_i (core_valid),
    .busy_o       (busy),
    .timeout_o    (tmo)
  );

  // Core model: result = (X ^ 0xA5, Z) unless fixed values are selected.
  logic          model_fixed = 1'b0;
  logic          model_never = 1'b0;
  logic          force_cv    = 1'b0;
  logic [DW-1:0] fx = '0, fy = '0, mx, my;
  int unsigned   lat;
  logic          cv_m;
  int            strb_cnt = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lat <= 0; cv_m <= 1'b0; mx <= '0; my <= '0;
    end else begin
      cv_m <= 1'b0;
      if (core_strb) begin
        lat <= CORE_LATENCY;
        mx  <= model_fixed ? fx : (core_xo ^ 8'hA5);
        my  <= model_fixed ? fy : core_zo;
      end else if (lat != 0) begin
        lat <= lat - 1;
        if (lat == 1 && !model_never) cv_m <= 1'b1;
      end
    end
  end
  assign core_valid = cv_m | force_cv;
  assign core_xi    = mx;
  assign core_yi    = my;

  always @(posedge clk) if (core_strb) strb_cnt <= strb_cnt + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Wait (bounded) for rsp valid on ch; report cycles and core_valid one cycle earlier.
  task automatic wait_rsp(input int ch, output int cyc, output logic cv_prev);
    logic cvp;
    bit   hit;
    cyc = 0; cv_prev = 1'b0; hit = 0;
    for (int i = 1; i <= 100 && !hit; i++) begin
      cvp = core_valid;
      @(negedge clk);
      if (rsp_valid[ch]) begin
        cyc = i; cv_prev = cvp; hit = 1;
      end
    end
    if (!hit) check("rsp_arrive", 0, 1);
  endtask

  // Called while ready[ch] is high; runs one normal transaction, rsp_ready[ch] assumed high.
  task automatic serve(input int ch, input logic [DW-1:0] x, input logic [DW-1:0] z);
    int   cyc;
    logic cvp;
    @(negedge clk);
    req_valid[ch] = 1'b0;
    check("strb", core_strb, 1);
    check("core_x", core_xo, 32'(x));
    check("core_z", core_zo, 32'(z));
    wait_rsp(ch, cyc, cvp);
    check("rsp_lat", cvp, 1);
    check("rsp_x", rsp_x[ch], 32'(x ^ 8'hA5));
    check("rsp_y", rsp_y[ch], 32'(z));
    check("rsp_err", rsp_err[ch], 0);
    check("rsp_other", rsp_valid[1-ch], 0);
    @(negedge clk);
  endtask

  typedef struct {
    logic          v0, v1;
    logic [DW-1:0] x0, z0, x1, z1;
    logic          first;
  } vec_t;

  vec_t tbl [8];

  task automatic run_vec(input vec_t v);
    logic [DW-1:0] xs [2];
    logic [DW-1:0] zs [2];
    int f, o;
    xs[0] = v.x0; zs[0] = v.z0; xs[1] = v.x1; zs[1] = v.z1;
    f = int'(v.first); o = 1 - f;
    rsp_ready = 2'b11;
    req_x[0] = v.x0; req_z[0] = v.z0; req_x[1] = v.x1; req_z[1] = v.z1;
    req_valid = {v.v1, v.v0};
    #1;
    check("grant_rdy", req_ready[f], 1);
    check("grant_excl", req_ready[o], 0);
    serve(f, xs[f], zs[f]);
    if (v.v0 && v.v1) begin
      check("no_bubble", req_ready[o], 1);
      serve(o, xs[o], zs[o]);
    end
    check("idle_after", busy, 0);
  endtask

  initial begin
    int   cyc, s0, bad_a, bad_b, bad_c;
    logic cvp;

    tbl[0] = '{1'b1, 1'b1, 8'h10, 8'h20, 8'h30, 8'h40, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 8'h7F, 8'h01, 8'h80, 8'hFF, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 8'h00, 8'h00, 8'h5A, 8'hA5, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 8'hC3, 8'h3C, 8'h01, 8'h7E, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h44, 8'h55, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 8'h66, 8'h77, 8'h00, 8'h00, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 8'h12, 8'h34, 8'h56, 8'h78, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 8'h9A, 8'hBC, 8'h00, 8'h00, 1'b0};

    rstn = 1'b1;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_x[0] = '0; req_z[0] = '0; req_x[1] = '0; req_z[1] = '0;

    // Reset state, with both requests pending so ready gating is exercised.
    #1 rstn = 1'b0;
    req_valid = 2'b11;
    #1;
    check("rst_ready0", req_ready[0], 0);
    check("rst_ready1", req_ready[1], 0);
    check("rst_busy", busy, 0);
    check("rst_strb", core_strb, 0);
    check("rst_rspv", rsp_valid, 0);
    check("rst_err", rsp_err, 0);
    check("rst_tmo", tmo, 0);
    check("rst_corex", core_xo, 0);
    check("rst_rspx", rsp_x[0], 0);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Round-robin table: first four are tie pairs straight from reset.
    for (int i = 0; i < 8; i++) run_vec(tbl[i]);
    rsp_ready = 2'b00;

    // Fixed-result single transaction on channel 0.
    model_fixed = 1'b1; fx = 8'h55; fy = 8'h2C;
    s0 = strb_cnt;
    rsp_ready = 2'b01;
    req_x[0] = 8'h60; req_z[0] = 8'h20; req_valid = 2'b01;
    #1;
    check("s_ready0", req_ready[0], 1);
    check("s_ready1", req_ready[1], 0);
    @(negedge clk);
    req_valid = 2'b00;
    check("s_strb", core_strb, 1);
    check("s_corex", core_xo, 32'h60);
    check("s_corez", core_zo, 32'h20);
    wait_rsp(0, cyc, cvp);
    check("s_lat", cvp, 1);
    check("s_rspx", rsp_x[0], 32'h55);
    check("s_rspy", rsp_y[0], 32'h2C);
    check("s_err", rsp_err[0], 0);
    check("s_rsp1", rsp_valid[1], 0);
    @(negedge clk);
    check("s_strb_cnt", 32'(strb_cnt - s0), 1);
    check("s_idle", busy, 0);
    model_fixed = 1'b0;

    // Timeout: the core never answers.
    model_never = 1'b1;
    rsp_ready = 2'b10;
    req_x[1] = 8'h11; req_z[1] = 8'h22; req_valid = 2'b10;
    #1;
    check("t_ready1", req_ready[1], 1);
    @(negedge clk);
    req_valid = 2'b00;
    check("t_strb", core_strb, 1);
    wait_rsp(1, cyc, cvp);
    check("t_cycles", 32'(cyc), 33);
    check("t_rspx", rsp_x[1], 0);
    check("t_rspy", rsp_y[1], 0);
    check("t_err", rsp_err[1], 1);
    check("t_tmo", tmo, 1);
    @(negedge clk);
    check("t_tmo_sticky", tmo, 1);
    check("t_idle", busy, 0);
    model_never = 1'b0;

    // Response back-pressure on channel 1 with channel 0 waiting.
    rsp_ready = 2'b00;
    req_x[1] = 8'h3C; req_z[1] = 8'h5A; req_valid = 2'b10;
    #1;
    check("b_ready1", req_ready[1], 1);
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp(1, cyc, cvp);
    check("b_rspx", rsp_x[1], 32'(8'h3C ^ 8'hA5));
    req_x[0] = 8'h77; req_z[0] = 8'h19; req_valid = 2'b01;
    bad_a = 0; bad_b = 0; bad_c = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_x[1] !== (8'h3C ^ 8'hA5) || rsp_y[1] !== 8'h5A || rsp_valid[1] !== 1'b1 || rsp_err[1] !== 1'b0)
        bad_a++;
      if (core_strb !== 1'b0) bad_b++;
      if (req_ready[0] !== 1'b0) bad_c++;
    end
    check("b_stable", 32'(bad_a), 0);
    check("b_no_strb", 32'(bad_b), 0);
    check("b_no_ready0", 32'(bad_c), 0);
    rsp_ready = 2'b11;
    @(negedge clk);
    check("b_ready0", req_ready[0], 1);
    serve(0, 8'h77, 8'h19);
    check("b_idle", busy, 0);

    // Reset pulse during WAIT.
    req_x[0] = 8'h42; req_z[0] = 8'h24; req_valid = 2'b01;
    #1;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    check("r_busy_pre", busy, 1);
    #2;
    req_valid = 2'b11;
    rstn = 1'b0;
    #1;
    check("r_busy", busy, 0);
    check("r_strb", core_strb, 0);
    check("r_ready", req_ready, 0);
    check("r_rspv", rsp_valid, 0);
    check("r_err", rsp_err, 0);
    check("r_tmo", tmo, 0);
    check("r_corex", core_xo, 0);
    req_valid = 2'b00;
    @(negedge clk);
    rstn = 1'b1;
    bad_a = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00 || busy !== 1'b0) bad_a++;
    end
    check("r_no_rsp", 32'(bad_a), 0);
    req_x[1] = 8'h6E; req_z[1] = 8'h13; req_valid = 2'b10;
    #1;
    check("r_ready1", req_ready[1], 1);
    serve(1, 8'h6E, 8'h13);
    check("r_idle", busy, 0);

    // Stray core_valid while idle.
    @(negedge clk);
    force_cv = 1'b1;
    @(negedge clk);
    force_cv = 1'b0;
    bad_a = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00 || busy !== 1'b0) bad_a++;
    end
    check("i_ignore", 32'(bad_a), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
